// File: rtl/crtc_pkg.sv
// crtc_pkg: register indices, reset values, width masks and status bit
// positions shared by the 6545-style CRTC register file.
package crtc_pkg;

  localparam logic [4:0] R0_H_TOTAL       = 5'd0;
  localparam logic [4:0] R1_H_DISPLAYED   = 5'd1;
  localparam logic [4:0] R2_H_SYNC_POS    = 5'd2;
  localparam logic [4:0] R3_SYNC_WIDTH    = 5'd3;
  localparam logic [4:0] R4_V_TOTAL       = 5'd4;
  localparam logic [4:0] R5_V_ADJUST      = 5'd5;
  localparam logic [4:0] R6_V_DISPLAYED   = 5'd6;
  localparam logic [4:0] R7_V_SYNC_POS    = 5'd7;
  localparam logic [4:0] R8_MODE          = 5'd8;
  localparam logic [4:0] R9_SCAN_LINES    = 5'd9;
  localparam logic [4:0] R10_CURSOR_START = 5'd10;
  localparam logic [4:0] R11_CURSOR_END   = 5'd11;
  localparam logic [4:0] R12_START_HI     = 5'd12;
  localparam logic [4:0] R13_START_LO     = 5'd13;
  localparam logic [4:0] R14_CURSOR_HI    = 5'd14;
  localparam logic [4:0] R15_CURSOR_LO    = 5'd15;
  localparam logic [4:0] R16_LPEN_HI      = 5'd16;
  localparam logic [4:0] R17_LPEN_LO      = 5'd17;

  localparam logic [7:0] R0_RESET  = 8'd63;
  localparam logic [7:0] R1_RESET  = 8'd40;
  localparam logic [7:0] R2_RESET  = 8'd48;
  localparam logic [7:0] R3_RESET  = 8'h15;
  localparam logic [7:0] R4_RESET  = 8'd32;
  localparam logic [7:0] R5_RESET  = 8'd0;
  localparam logic [7:0] R6_RESET  = 8'd25;
  localparam logic [7:0] R7_RESET  = 8'd28;
  localparam logic [7:0] R8_RESET  = 8'd0;
  localparam logic [7:0] R9_RESET  = 8'd7;
  localparam logic [7:0] R10_RESET = 8'd0;
  localparam logic [7:0] R11_RESET = 8'd0;
  localparam logic [7:0] R12_RESET = 8'h10;
  localparam logic [7:0] R13_RESET = 8'd0;
  localparam logic [7:0] R14_RESET = 8'd0;
  localparam logic [7:0] R15_RESET = 8'd0;
  localparam logic [7:0] R16_RESET = 8'd0;
  localparam logic [7:0] R17_RESET = 8'd0;

  localparam logic [7:0] R0_MASK  = 8'hFF;
  localparam logic [7:0] R1_MASK  = 8'hFF;
  localparam logic [7:0] R2_MASK  = 8'hFF;
  localparam logic [7:0] R3_MASK  = 8'hFF;
  localparam logic [7:0] R4_MASK  = 8'h7F;
  localparam logic [7:0] R5_MASK  = 8'h1F;
  localparam logic [7:0] R6_MASK  = 8'h7F;
  localparam logic [7:0] R7_MASK  = 8'h7F;
  localparam logic [7:0] R8_MASK  = 8'hFF;
  localparam logic [7:0] R9_MASK  = 8'h1F;
  localparam logic [7:0] R10_MASK = 8'h7F;
  localparam logic [7:0] R11_MASK = 8'h1F;
  localparam logic [7:0] R12_MASK = 8'h3F;
  localparam logic [7:0] R13_MASK = 8'hFF;
  localparam logic [7:0] R14_MASK = 8'h3F;
  localparam logic [7:0] R15_MASK = 8'hFF;
  localparam logic [7:0] R16_MASK = 8'h3F;
  localparam logic [7:0] R17_MASK = 8'hFF;

  localparam int ST_PENDING   = 7;
  localparam int ST_LPEN_FULL = 6;
  localparam int ST_VBLANK    = 5;

  // Writable register slots (R0..R15); R16/R17 are read-only.
  localparam int NUM_WR_REGS = 16;

  function automatic logic [7:0] reg_mask(input logic [4:0] idx);
    case (idx)
      R0_H_TOTAL:       return R0_MASK;
      R1_H_DISPLAYED:   return R1_MASK;
      R2_H_SYNC_POS:    return R2_MASK;
      R3_SYNC_WIDTH:    return R3_MASK;
      R4_V_TOTAL:       return R4_MASK;
      R5_V_ADJUST:      return R5_MASK;
      R6_V_DISPLAYED:   return R6_MASK;
      R7_V_SYNC_POS:    return R7_MASK;
      R8_MODE:          return R8_MASK;
      R9_SCAN_LINES:    return R9_MASK;
      R10_CURSOR_START: return R10_MASK;
      R11_CURSOR_END:   return R11_MASK;
      R12_START_HI:     return R12_MASK;
      R13_START_LO:     return R13_MASK;
      R14_CURSOR_HI:    return R14_MASK;
      R15_CURSOR_LO:    return R15_MASK;
      R16_LPEN_HI:      return R16_MASK;
      R17_LPEN_LO:      return R17_MASK;
      default:          return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] reg_reset(input logic [4:0] idx);
    case (idx)
      R0_H_TOTAL:       return R0_RESET;
      R1_H_DISPLAYED:   return R1_RESET;
      R2_H_SYNC_POS:    return R2_RESET;
      R3_SYNC_WIDTH:    return R3_RESET;
      R4_V_TOTAL:       return R4_RESET;
      R5_V_ADJUST:      return R5_RESET;
      R6_V_DISPLAYED:   return R6_RESET;
      R7_V_SYNC_POS:    return R7_RESET;
      R8_MODE:          return R8_RESET;
      R9_SCAN_LINES:    return R9_RESET;
      R10_CURSOR_START: return R10_RESET;
      R11_CURSOR_END:   return R11_RESET;
      R12_START_HI:     return R12_RESET;
      R13_START_LO:     return R13_RESET;
      R14_CURSOR_HI:    return R14_RESET;
      R15_CURSOR_LO:    return R15_RESET;
      default:          return 8'h00;
    endcase
  endfunction

  // Timing and display-start registers are shadowed until the next v_sync.
  function automatic logic is_buffered(input logic [4:0] idx);
    return (idx <= R9_SCAN_LINES) || (idx == R12_START_HI) || (idx == R13_START_LO);
  endfunction

endpackage

// File: rtl/crtc_regs_if.sv
// crtc_regs_if: CPU-side register bus of the CRTC (select, strobes, data).
interface crtc_regs_if;
  logic       rs_i;
  logic       wr_strobe_i;
  logic       rd_strobe_i;
  logic [7:0] data_i;
  logic [7:0] data_o;

  modport master (
    output rs_i, wr_strobe_i, rd_strobe_i, data_i,
    input  data_o
  );

  modport slave (
    input  rs_i, wr_strobe_i, rd_strobe_i, data_i,
    output data_o
  );
endinterface

// File: rtl/crtc_lpen_latch.sv
// crtc_lpen_latch: light-pen edge detector, 14-bit refresh-address latch and
// full flag. A capture is refused while full; a clearing read beats a
// coincident capture so the CPU never loses the value it is reading.
module crtc_lpen_latch (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        lpen_i,
  input  logic [13:0] ma_i,
  input  logic        clear_i,
  output logic [13:0] lpen_addr_o,
  output logic        full_o
);

  logic        lpen_q;
  logic [13:0] addr_q;
  logic        full_q;
  logic        lpen_rise;

  assign lpen_rise = lpen_i & ~lpen_q;

  // Edge history, capture and full flag with clear priority.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lpen_q <= 1'b0;
      addr_q <= '0;
      full_q <= 1'b0;
    end else begin
      lpen_q <= lpen_i;
      if (clear_i) begin
        full_q <= 1'b0;
      end else if (lpen_rise && !full_q) begin
        addr_q <= ma_i;
        full_q <= 1'b1;
      end
    end
  end

  assign lpen_addr_o = addr_q;
  assign full_o      = full_q;

endmodule

// File: rtl/crtc_regs.sv
// crtc_regs: 6545-style CRTC register file. Timing registers are shadowed and
// copied live on each v_sync rising edge; cursor registers are immediate.
// Optional light-pen latch is built when CRTC_LIGHTPEN_EN is defined.
module crtc_regs
  import crtc_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  crtc_regs_if.slave        bus,
  input  logic              v_sync_i,
  input  logic              v_active_i,
  input  logic              lpen_i,
  input  logic [13:0]       ma_i,
  output logic [7:0]        h_total_o,
  output logic [7:0]        h_displayed_o,
  output logic [7:0]        h_sync_pos_o,
  output logic [7:0]        sync_width_o,
  output logic [6:0]        v_total_o,
  output logic [4:0]        v_adjust_o,
  output logic [6:0]        v_displayed_o,
  output logic [6:0]        v_sync_pos_o,
  output logic [7:0]        mode_o,
  output logic [4:0]        scan_lines_o,
  output logic [13:0]       display_start_o,
  output logic [1:0]        cursor_mode_o,
  output logic [4:0]        cursor_start_o,
  output logic [4:0]        cursor_end_o,
  output logic [13:0]       cursor_addr_o
);

  logic [4:0] addr_q;
  logic       v_sync_q;
  logic       pending_q;
  logic [7:0] shadow_q [NUM_WR_REGS];
  logic [7:0] live_q   [NUM_WR_REGS];
  logic [7:0] r10_q, r11_q, r14_q, r15_q;

  logic       addr_wr;
  logic       data_wr;
  logic       buf_wr;
  logic       vs_rise;
  logic [7:0] wdata_m;

  logic [13:0] lpen_addr;
  logic        lpen_full;

  assign addr_wr = bus.wr_strobe_i & ~bus.rs_i;
  assign data_wr = bus.wr_strobe_i &  bus.rs_i;
  assign buf_wr  = data_wr & is_buffered(addr_q);
  assign vs_rise = v_sync_i & ~v_sync_q;
  assign wdata_m = bus.data_i & reg_mask(addr_q);

  // Address register, v_sync edge history and the pending flag. A write in
  // the same cycle as a v_sync rise keeps pending set for the next frame.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_q    <= '0;
      v_sync_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      v_sync_q <= v_sync_i;
      if (addr_wr)
        addr_q <= bus.data_i[4:0];
      if (buf_wr)
        pending_q <= 1'b1;
      else if (vs_rise)
        pending_q <= 1'b0;
    end
  end

  // Shadow copies of the buffered registers; unbuffered slots stay at zero.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_WR_REGS; i++)
        shadow_q[i] <= reg_reset(5'(i));
    end else if (buf_wr) begin
      shadow_q[addr_q[3:0]] <= wdata_m;
    end
  end

  // Live timing copy: takes the pre-write shadow on every v_sync rise.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_WR_REGS; i++)
        live_q[i] <= reg_reset(5'(i));
    end else if (vs_rise) begin
      live_q <= shadow_q;
    end
  end

  // Immediate cursor registers, visible on the strobe edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r10_q <= R10_RESET;
      r11_q <= R11_RESET;
      r14_q <= R14_RESET;
      r15_q <= R15_RESET;
    end else if (data_wr) begin
      case (addr_q)
        R10_CURSOR_START: r10_q <= wdata_m;
        R11_CURSOR_END:   r11_q <= wdata_m;
        R14_CURSOR_HI:    r14_q <= wdata_m;
        R15_CURSOR_LO:    r15_q <= wdata_m;
        default: ;
      endcase
    end
  end

`ifdef CRTC_LIGHTPEN_EN
  logic lpen_clear;
  assign lpen_clear = bus.rd_strobe_i & bus.rs_i &
                      ((addr_q == R16_LPEN_HI) | (addr_q == R17_LPEN_LO));

  crtc_lpen_latch u_lpen (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .lpen_i      (lpen_i),
    .ma_i        (ma_i),
    .clear_i     (lpen_clear),
    .lpen_addr_o (lpen_addr),
    .full_o      (lpen_full)
  );
`else
  // Without the light pen these inputs have no function.
  logic unused_lpen;
  assign unused_lpen = ^{lpen_i, ma_i, bus.rd_strobe_i};
  assign lpen_addr   = '0;
  assign lpen_full   = 1'b0;
`endif

  // CPU read mux: status on rs=0, R14..R17 on rs=1, everything else zero.
  always_comb begin
    bus.data_o = '0;
    if (!bus.rs_i) begin
      bus.data_o[ST_PENDING]   = pending_q;
      bus.data_o[ST_LPEN_FULL] = lpen_full;
      bus.data_o[ST_VBLANK]    = ~v_active_i;
    end else begin
      case (addr_q)
        R14_CURSOR_HI: bus.data_o = r14_q;
        R15_CURSOR_LO: bus.data_o = r15_q;
        R16_LPEN_HI:   bus.data_o = {2'b00, lpen_addr[13:8]};
        R17_LPEN_LO:   bus.data_o = lpen_addr[7:0];
        default:       bus.data_o = '0;
      endcase
    end
  end

  assign h_total_o       = live_q[R0_H_TOTAL[3:0]];
  assign h_displayed_o   = live_q[R1_H_DISPLAYED[3:0]];
  assign h_sync_pos_o    = live_q[R2_H_SYNC_POS[3:0]];
  assign sync_width_o    = live_q[R3_SYNC_WIDTH[3:0]];
  assign v_total_o       = live_q[R4_V_TOTAL[3:0]][6:0];
  assign v_adjust_o      = live_q[R5_V_ADJUST[3:0]][4:0];
  assign v_displayed_o   = live_q[R6_V_DISPLAYED[3:0]][6:0];
  assign v_sync_pos_o    = live_q[R7_V_SYNC_POS[3:0]][6:0];
  assign mode_o          = live_q[R8_MODE[3:0]];
  assign scan_lines_o    = live_q[R9_SCAN_LINES[3:0]][4:0];
  assign display_start_o = {live_q[R12_START_HI[3:0]][5:0], live_q[R13_START_LO[3:0]]};

  assign cursor_mode_o   = r10_q[6:5];
  assign cursor_start_o  = r10_q[4:0];
  assign cursor_end_o    = r11_q[4:0];
  assign cursor_addr_o   = {r14_q[5:0], r15_q};

endmodule

// File: tb/tb_crtc_regs.sv
// tb_crtc_regs: directed scenarios plus randomized traffic checked against a
// register-level reference model of the CRTC register file.
module tb_crtc_regs;

`ifdef CRTC_LIGHTPEN_EN
  localparam bit LPEN = 1'b1;
`else
  localparam bit LPEN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_sync_i, v_active_i, lpen_i;
  logic [13:0] ma_i;
  logic [7:0]  h_total_o, h_displayed_o, h_sync_pos_o, sync_width_o, mode_o;
  logic [6:0]  v_total_o, v_displayed_o, v_sync_pos_o;
  logic [4:0]  v_adjust_o, scan_lines_o, cursor_start_o, cursor_end_o;
  logic [13:0] display_start_o, cursor_addr_o;
  logic [1:0]  cursor_mode_o;

  crtc_regs_if bus();

  crtc_regs dut (
    .clk_i(clk_i), .reset_i(reset_i), .bus(bus.slave),
    .v_sync_i(v_sync_i), .v_active_i(v_active_i), .lpen_i(lpen_i), .ma_i(ma_i),
    .h_total_o(h_total_o), .h_displayed_o(h_displayed_o), .h_sync_pos_o(h_sync_pos_o),
    .sync_width_o(sync_width_o), .v_total_o(v_total_o), .v_adjust_o(v_adjust_o),
    .v_displayed_o(v_displayed_o), .v_sync_pos_o(v_sync_pos_o), .mode_o(mode_o),
    .scan_lines_o(scan_lines_o), .display_start_o(display_start_o),
    .cursor_mode_o(cursor_mode_o), .cursor_start_o(cursor_start_o),
    .cursor_end_o(cursor_end_o), .cursor_addr_o(cursor_addr_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [84:0] act_timing;
  logic [25:0] act_cursor;
  assign act_timing = {h_total_o, h_displayed_o, h_sync_pos_o, sync_width_o, v_total_o,
                       v_adjust_o, v_displayed_o, v_sync_pos_o, mode_o, scan_lines_o,
                       display_start_o};
  assign act_cursor = {cursor_mode_o, cursor_start_o, cursor_end_o, cursor_addr_o};

  // Reference model: register contents as the CPU and video_gen see them.
  logic [7:0] m_shadow [18];
  logic [7:0] m_live   [18];
  logic [4:0] m_addr;
  bit         m_pend, m_full, m_vsq, m_lpq;

  function automatic logic [7:0] t_mask(input int i);
    int w;
    case (i)
      0, 1, 2, 3, 8, 13, 15, 17: w = 8;
      4, 6, 7, 10:               w = 7;
      12, 14, 16:                w = 6;
      5, 9, 11:                  w = 5;
      default:                   w = 0;
    endcase
    return 8'((1 << w) - 1);
  endfunction

  function automatic logic [7:0] t_reset(input int i);
    case (i)
      0: return 8'd63;  1: return 8'd40;  2: return 8'd48; 3: return 8'h15;
      4: return 8'd32;  6: return 8'd25;  7: return 8'd28; 9: return 8'd7;
      12: return 8'h10;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit t_deferred(input int i);
    return (i < 10) || (i == 12) || (i == 13);
  endfunction

  function automatic logic [84:0] exp_timing();
    return {m_live[0], m_live[1], m_live[2], m_live[3], m_live[4][6:0], m_live[5][4:0],
            m_live[6][6:0], m_live[7][6:0], m_live[8], m_live[9][4:0],
            m_live[12][5:0], m_live[13]};
  endfunction

  function automatic logic [25:0] exp_cursor();
    return {m_live[10][6:5], m_live[10][4:0], m_live[11][4:0], m_live[14][5:0], m_live[15]};
  endfunction

  function automatic logic [7:0] exp_rd();
    if (!bus.rs_i) return {m_pend, m_full, ~v_active_i, 5'b0};
    if (m_addr >= 14 && m_addr <= 17) return m_live[m_addr];
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 18; i++) begin
      m_shadow[i] = t_reset(i);
      m_live[i]   = t_reset(i);
    end
    m_addr = 0; m_pend = 0; m_full = 0; m_vsq = 0; m_lpq = 0;
  endtask

  // Advance the model by one clock using the inputs now applied, then clock the DUT.
  task automatic tick();
    logic [7:0] v;
    if (v_sync_i && !m_vsq) begin
      for (int i = 0; i < 18; i++) if (t_deferred(i)) m_live[i] = m_shadow[i];
      m_pend = 0;
    end
    if (bus.wr_strobe_i && !bus.rs_i) m_addr = bus.data_i[4:0];
    if (bus.wr_strobe_i && bus.rs_i && m_addr < 16) begin
      v = bus.data_i & t_mask(int'(m_addr));
      if (t_deferred(int'(m_addr))) begin m_shadow[m_addr] = v; m_pend = 1; end
      else m_live[m_addr] = v;
    end
    if (LPEN) begin
      if (bus.rd_strobe_i && bus.rs_i && (m_addr == 16 || m_addr == 17)) m_full = 0;
      else if (lpen_i && !m_lpq && !m_full) begin
        m_live[16] = {2'b00, ma_i[13:8]};
        m_live[17] = ma_i[7:0];
        m_full = 1;
      end
    end
    m_vsq = v_sync_i;
    m_lpq = lpen_i;
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    model_reset();
    @(posedge clk_i); #1;
    reset_i = 1'b0;
  endtask

  task automatic wr_addr(input logic [7:0] a);
    bus.rs_i = 1'b0; bus.wr_strobe_i = 1'b1; bus.data_i = a;
    tick();
    bus.wr_strobe_i = 1'b0;
  endtask

  task automatic wr_data(input logic [7:0] d);
    bus.rs_i = 1'b1; bus.wr_strobe_i = 1'b1; bus.data_i = d;
    tick();
    bus.wr_strobe_i = 1'b0;
  endtask

  task automatic vs_pulse();
    v_sync_i = 1'b1; tick();
    v_sync_i = 1'b0; tick();
  endtask

  task automatic test_reset();
    bus.rs_i = 0; bus.wr_strobe_i = 0; bus.rd_strobe_i = 0; bus.data_i = 0;
    v_sync_i = 0; v_active_i = 0; lpen_i = 0; ma_i = 0;
    do_reset();
    n_checks++;
    if (h_total_o !== 8'd63) begin n_fail++; $display("FAIL reset_h_total got %0d want 63", h_total_o); end
    n_checks++;
    if (display_start_o !== 14'h1000) begin n_fail++; $display("FAIL reset_display_start got %h want 1000", display_start_o); end
    n_checks++;
    if (bus.data_o !== 8'h20) begin n_fail++; $display("FAIL reset_status got %h want 20", bus.data_o); end
    n_checks++;
    if (act_timing !== exp_timing() || act_cursor !== 26'd0) begin
      n_fail++; $display("FAIL reset_all_outputs got %h/%h want %h/0", act_timing, act_cursor, exp_timing());
    end
  endtask

  task automatic test_deferred();
    wr_addr(8'd1); wr_data(8'h28); wr_data(8'h20);
    bus.rs_i = 0; #1;
    n_checks++;
    if (h_displayed_o !== 8'd40) begin n_fail++; $display("FAIL deferred_hold got %0d want 40", h_displayed_o); end
    n_checks++;
    if (bus.data_o[7] !== 1'b1) begin n_fail++; $display("FAIL deferred_pending_set got %b want 1", bus.data_o[7]); end
    v_sync_i = 1; tick();
    n_checks++;
    if (h_displayed_o !== 8'd32) begin n_fail++; $display("FAIL deferred_apply got %0d want 32", h_displayed_o); end
    n_checks++;
    if (bus.data_o[7] !== 1'b0) begin n_fail++; $display("FAIL deferred_pending_clr got %b want 0", bus.data_o[7]); end
    v_sync_i = 0; tick();
  endtask

  task automatic test_immediate();
    wr_addr(8'd14); wr_data(8'hFF);
    n_checks++;
    if (cursor_addr_o[13:8] !== 6'h3F) begin n_fail++; $display("FAIL imm_cursor_hi got %h want 3f", cursor_addr_o[13:8]); end
    n_checks++;
    if (bus.data_o !== 8'h3F) begin n_fail++; $display("FAIL imm_readback got %h want 3f", bus.data_o); end
    wr_addr(8'd15); wr_data(8'h5A);
    n_checks++;
    if (cursor_addr_o !== 14'h3F5A) begin n_fail++; $display("FAIL imm_cursor_addr got %h want 3f5a", cursor_addr_o); end
    wr_addr(8'd1); bus.rs_i = 1; #1;
    n_checks++;
    if (bus.data_o !== 8'h00) begin n_fail++; $display("FAIL read_r1_zero got %h want 00", bus.data_o); end
  endtask

  task automatic test_vsync_coincident();
    wr_addr(8'd6);
    bus.rs_i = 1; bus.wr_strobe_i = 1; bus.data_i = 8'd20; v_sync_i = 1;
    tick();
    bus.wr_strobe_i = 0;
    n_checks++;
    if (v_displayed_o !== 7'd25) begin n_fail++; $display("FAIL coinc_old_value got %0d want 25", v_displayed_o); end
    bus.rs_i = 0; #1;
    n_checks++;
    if (bus.data_o[7] !== 1'b1) begin n_fail++; $display("FAIL coinc_pending got %b want 1", bus.data_o[7]); end
    v_sync_i = 0; tick();
    v_sync_i = 1; tick();
    n_checks++;
    if (v_displayed_o !== 7'd20) begin n_fail++; $display("FAIL coinc_next_apply got %0d want 20", v_displayed_o); end
    wr_data(8'd10); tick(); tick();
    n_checks++;
    if (v_displayed_o !== 7'd20) begin n_fail++; $display("FAIL vsync_held_once got %0d want 20", v_displayed_o); end
    v_sync_i = 0; tick();
    v_sync_i = 1; tick();
    n_checks++;
    if (v_displayed_o !== 7'd10) begin n_fail++; $display("FAIL vsync_reapply got %0d want 10", v_displayed_o); end
    v_sync_i = 0; tick();
  endtask

  task automatic test_lightpen();
    lpen_i = 0; tick();
    ma_i = 14'h0ABC; lpen_i = 1; tick(); lpen_i = 0; tick();
    wr_addr(8'd16); bus.rs_i = 1; #1;
    n_checks++;
    if (bus.data_o !== (LPEN ? 8'h0A : 8'h00)) begin n_fail++; $display("FAIL lpen_r16 got %h want %h", bus.data_o, LPEN ? 8'h0A : 8'h00); end
    wr_addr(8'd17); bus.rs_i = 1; #1;
    n_checks++;
    if (bus.data_o !== (LPEN ? 8'hBC : 8'h00)) begin n_fail++; $display("FAIL lpen_r17 got %h want %h", bus.data_o, LPEN ? 8'hBC : 8'h00); end
    bus.rs_i = 0; #1;
    n_checks++;
    if (bus.data_o[6] !== LPEN) begin n_fail++; $display("FAIL lpen_full_flag got %b want %b", bus.data_o[6], LPEN); end
    if (LPEN) begin
      ma_i = 14'h0123; lpen_i = 1; tick(); lpen_i = 0; tick();
      bus.rs_i = 1; #1;
      n_checks++;
      if (bus.data_o !== 8'hBC) begin n_fail++; $display("FAIL lpen_drop_when_full got %h want bc", bus.data_o); end
      bus.rd_strobe_i = 1; tick(); bus.rd_strobe_i = 0;
      bus.rs_i = 0; #1;
      n_checks++;
      if (bus.data_o[6] !== 1'b0) begin n_fail++; $display("FAIL lpen_read_clear got %b want 0", bus.data_o[6]); end
      ma_i = 14'h1555; lpen_i = 1; tick(); lpen_i = 0; tick();
      ma_i = 14'h0777; bus.rs_i = 1; bus.rd_strobe_i = 1; lpen_i = 1; #1;
      n_checks++;
      if (bus.data_o !== 8'h55) begin n_fail++; $display("FAIL lpen_coinc_old got %h want 55", bus.data_o); end
      tick(); bus.rd_strobe_i = 0;
      n_checks++;
      if (bus.data_o !== 8'h55) begin n_fail++; $display("FAIL lpen_coinc_dropped got %h want 55", bus.data_o); end
      bus.rs_i = 0; #1;
      n_checks++;
      if (bus.data_o[6] !== 1'b0) begin n_fail++; $display("FAIL lpen_coinc_clear got %b want 0", bus.data_o[6]); end
      lpen_i = 0; tick();
    end
  endtask

  task automatic test_masking();
    wr_addr(8'd9); wr_data(8'hFF); vs_pulse();
    n_checks++;
    if (scan_lines_o !== 5'h1F) begin n_fail++; $display("FAIL mask_r9 got %h want 1f", scan_lines_o); end
    wr_addr(8'd10); wr_data(8'hFF);
    n_checks++;
    if (cursor_mode_o !== 2'd3 || cursor_start_o !== 5'h1F) begin
      n_fail++; $display("FAIL mask_r10 got %0d/%h want 3/1f", cursor_mode_o, cursor_start_o);
    end
    wr_addr(8'd20); wr_data(8'hAA);
    bus.rs_i = 1; #1;
    n_checks++;
    if (bus.data_o !== 8'h00) begin n_fail++; $display("FAIL addr20_read got %h want 00", bus.data_o); end
    bus.rs_i = 0; #1;
    n_checks++;
    if (bus.data_o[7] !== 1'b0) begin n_fail++; $display("FAIL addr20_no_pending got %b want 0", bus.data_o[7]); end
    vs_pulse();
    n_checks++;
    if (act_timing !== exp_timing() || act_cursor !== exp_cursor()) begin
      n_fail++; $display("FAIL addr20_no_change got %h/%h want %h/%h", act_timing, act_cursor, exp_timing(), exp_cursor());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      bus.rs_i        = 1'($urandom);
      bus.wr_strobe_i = ($urandom_range(0, 2) == 0);
      bus.rd_strobe_i = ($urandom_range(0, 3) == 0);
      bus.data_i      = bus.rs_i ? 8'($urandom) : 8'($urandom_range(0, 23));
      if ($urandom_range(0, 5) == 0) v_sync_i = ~v_sync_i;
      if ($urandom_range(0, 4) == 0) lpen_i = ~lpen_i;
      v_active_i = 1'($urandom);
      ma_i       = 14'($urandom);
      tick();
      n_checks++;
      if (act_timing !== exp_timing()) begin
        n_fail++; $display("FAIL rand_timing[%0d] got %h want %h", n, act_timing, exp_timing());
      end
      n_checks++;
      if (act_cursor !== exp_cursor()) begin
        n_fail++; $display("FAIL rand_cursor[%0d] got %h want %h", n, act_cursor, exp_cursor());
      end
      n_checks++;
      if (bus.data_o !== exp_rd()) begin
        n_fail++; $display("FAIL rand_read[%0d] got %h want %h", n, bus.data_o, exp_rd());
      end
    end
    bus.wr_strobe_i = 0; bus.rd_strobe_i = 0;
  endtask

  initial begin
    test_reset();
    test_deferred();
    test_immediate();
    test_vsync_coincident();
    test_lightpen();
    test_masking();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crtc_regs.md
# crtc_regs

6545-style CRTC register file between the CPU bus and `video_gen`. Holds the CPU-visible address register and R0–R17, and drives the timing, display-start and cursor fields that `video_gen` consumes. Timing registers are double-buffered and take effect at the next vertical sync, so mid-frame writes never tear the raster. Light-pen capture is optional.

## Interface
- No parameters; register indices and reset values come from `crtc_pkg`.
- `clk_i` in 1: system clock; all inputs are synchronous to it.
- `reset_i` in 1: asynchronous, active-high.
- `rs_i` in 1: register select; 0 = address/status, 1 = data.
- `wr_strobe_i` in 1: one-cycle write qualifier.
- `rd_strobe_i` in 1: one-cycle read qualifier, used for side effects only.
- `data_i` in 8: CPU write data.
- `data_o` out 8: CPU read data; combinational.
- `v_sync_i`, `v_active_i` in 1: from `video_gen`.
- `lpen_i` in 1: light-pen strobe.
- `ma_i` in 14: current refresh address.
- `h_total_o`/8, `h_displayed_o`/8, `h_sync_pos_o`/8, `sync_width_o`/8, `v_total_o`/7, `v_adjust_o`/5, `v_displayed_o`/7, `v_sync_pos_o`/7, `mode_o`/8, `scan_lines_o`/5, `display_start_o`/14 out: live timing registers R0–R9, R12:R13.
- `cursor_mode_o`/2, `cursor_start_o`/5, `cursor_end_o`/5, `cursor_addr_o`/14 out: live cursor registers R10, R11, R14:R15.

## Operation
- **Address register** (`addr`, 5 bits): written by `wr_strobe_i` with `rs_i=0` from `data_i[4:0]`.
- **Data writes:** `wr_strobe_i` with `rs_i=1` writes `regs[addr]`, masked to the implemented width. Writes to `addr` ≥ 16 are ignored.
- **Implemented widths:** R0–R3 8; R4 7; R5 5; R6 7; R7 7; R8 8; R9 5; R10 7 (bits 6:5 = cursor mode, 4:0 = start); R11 5; R12 6; R13 8; R14 6; R15 8; R16 6; R17 8. Unimplemented bits read 0.
- **Double-buffered registers** (R0–R9, R12, R13): writes land in the shadow copy and set `pending`.
  - On a `v_sync_i` rising edge (`v_sync_i & ~v_sync_q`), all shadow values copy to the live outputs and `pending` clears.
- **Immediate registers** (R10, R11, R14, R15): write straight to the live outputs.
- **Status read** (`rs_i=0`): `data_o` = {`pending`, `lpen_full`, `~v_active_i`, 5'b0}.
- **Data read** (`rs_i=1`): only R14–R17 return contents; all other addresses return 0.
- **Read side effect:** `rd_strobe_i` with `rs_i=1` and `addr` of 16 or 17 clears `lpen_full`.
- **Light pen:** an `lpen_i` rising edge while `lpen_full=0` latches `ma_i` into R16:R17 and sets `lpen_full`. Edges while full are dropped.

## Timing
- **Reset values:**
  - Live and shadow: R0=63, R1=40, R2=48, R3=0x15, R4=32, R5=0, R6=25, R7=28, R8=0, R9=7, R12=0x10, R13=0.
  - R10, R11, R14–R17 = 0.
  - `addr`=0, `pending`=0, `lpen_full`=0, `v_sync_q`=0.
- **Write latency:** immediate registers update on the strobe edge. Timing outputs update on the first clock edge at which `v_sync_i`=1 and `v_sync_q`=0.
- **Write coincident with v_sync rise:** the copy uses the pre-write shadow value; the new value stays in shadow and `pending` remains 1.
- **Write to `addr` and data in one cycle:** impossible by construction, since `rs_i` is a single bit.
- **Clearing read coincident with lpen edge:** clear wins; the strobe is dropped. `data_o` shows the old latched value during that cycle.
- **Reset mid-frame:** all state returns to reset values immediately; the next v_sync copies the reset shadow values, which is harmless.
- **`v_sync_i` held high:** exactly one copy per rising edge.

## Configuration
- `CRTC_LIGHTPEN_EN` defined: light-pen latch present as described above.
- Undefined:
  - `lpen_i` and `ma_i` are ignored.
  - R16 and R17 read 0.
  - Status bit 6 reads 0.
  - No latch flops are synthesized.

## Structure
- `crtc_pkg` holds:
  - register index constants `R0_H_TOTAL` … `R17_LPEN_LO`;
  - reset-value constants `R*_RESET`;
  - per-register width masks;
  - status bit positions `ST_PENDING`=7, `ST_LPEN_FULL`=6, `ST_VBLANK`=5.
- One sub-module, `crtc_lpen_latch`, contains the edge detector, 14-bit latch, full flag and clear logic. It is instantiated only under `CRTC_LIGHTPEN_EN`.

## Test plan
- **Reset defaults:** reset → `h_total_o`=63, `display_start_o`=0x1000, status read = 0x20 while `v_active_i`=0.
- **Deferred write:** `addr`←1, data←0x28, then 0x20 → `h_displayed_o` stays 40 and status bit 7 = 1. `v_sync_i` rises → `h_displayed_o`=32 one edge later, bit 7 = 0.
- **Immediate write and read-back:** `addr`←14, write 0xFF → `cursor_addr_o[13:8]`=0x3F and read-back = 0x3F. `addr`←1 read → 0x00.
- **Write coincident with v_sync:** write R6=20 on the v_sync rise edge → `v_displayed_o` keeps its old value. The next v_sync rise applies 20.
- **Light pen capture:** with `CRTC_LIGHTPEN_EN`, `ma_i`=0x0ABC and `lpen_i` pulses → R16=0x0A, R17=0xBC, status bit 6 = 1. A second pulse with `ma_i`=0x0123 is ignored. Reading R17 clears bit 6.
- **Masking and ignored writes:** write 0xFF to R9 → 0x1F. Write to `addr`=20 → no register changes.
